// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arb_pkg
//  Description : Shared types and constants for the data-memory port arbiter:
//                FSM state encoding, requester identifiers and the idle
//                byte-enable value.
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,   // may grant one requester
      ST_RET  = 1'b1    // read return cycle, no grant
   } arb_state_e;

   // Requester identifiers; REQ_NONE marks "no lock owner".
   localparam logic [1:0] REQ_CORE = 2'd0;
   localparam logic [1:0] REQ_DBG  = 2'd1;
   localparam logic [1:0] REQ_NONE = 2'd2;

   localparam logic [3:0] BE_NONE  = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/dm_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way round-robin winner selector with a
//                bounded lock. A lock owner keeps winning until it has been
//                granted LOCK_MAX counted times while the other side waited.
//  Ports       : req_i        - request vector {r1, r0}
//                rr_last_i    - requester granted most recently
//                lock_owner_i - REQ_CORE / REQ_DBG / REQ_NONE
//                lock_cnt_i   - consecutive contended grants to the owner
//                winner_o     - selected requester (valid only with valid_o)
//                valid_o      - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
   import dm_arb_pkg::*;
#(
   parameter int LOCK_MAX   = 16,
   parameter int LOCK_CNT_W = 5
) (
   input  logic [1:0]            req_i,
   input  logic                  rr_last_i,
   input  logic [1:0]            lock_owner_i,
   input  logic [LOCK_CNT_W-1:0] lock_cnt_i,
   output logic                  winner_o,
   output logic                  valid_o
);

   logic w_locked;
   logic w_owner;
   logic w_other;
   logic w_cap;

   assign w_locked = (lock_owner_i != REQ_NONE);
   assign w_owner  = lock_owner_i[0];
   assign w_other  = ~w_owner;
   assign w_cap    = (lock_cnt_i >= LOCK_CNT_W'(LOCK_MAX));

   always_comb begin
      winner_o = 1'b0;
      valid_o  = |req_i;
      if (w_locked && req_i[w_owner] && (!req_i[w_other] || !w_cap)) begin
         winner_o = w_owner;
      end else if (req_i == 2'b11) begin
         // Cap reached: rotation is forced to the waiting side.
         winner_o = (w_locked && req_i[w_owner]) ? w_other : ~rr_last_i;
      end else begin
         winner_o = req_i[1];
      end
   end

endmodule
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_port_arbiter
//  Description : Shares the MMU data-memory port between the core LSU (r0)
//                and the debug/loader port (r1). Round-robin with bounded
//                lock; reads occupy an issue cycle plus a return cycle during
//                which byte-enable and sign are replayed to the MMU.
//  Ports       : clk, resetb        - clock, async active-low reset
//                rN_*_i             - requester N command fields
//                rN_gnt_o           - access accepted this cycle
//                rN_rvalid_o/rdata  - read return
//                m_*_o              - MMU dm_* command outputs
//                m_rdata_i          - MMU read data (dm_do)
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_port_arbiter
   import dm_arb_pkg::*;
#(
   parameter int LOCK_MAX   = 16,
   parameter int LOCK_CNT_W = 5
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        r0_req_i,
   input  logic        r0_we_i,
   input  logic [31:0] r0_addr_i,
   input  logic [31:0] r0_wdata_i,
   input  logic [3:0]  r0_be_i,
   input  logic        r0_signed_i,
   input  logic        r0_lock_i,
   output logic        r0_gnt_o,
   output logic        r0_rvalid_o,
   output logic [31:0] r0_rdata_o,
   input  logic        r1_req_i,
   input  logic        r1_we_i,
   input  logic [31:0] r1_addr_i,
   input  logic [31:0] r1_wdata_i,
   input  logic [3:0]  r1_be_i,
   input  logic        r1_signed_i,
   input  logic        r1_lock_i,
   output logic        r1_gnt_o,
   output logic        r1_rvalid_o,
   output logic [31:0] r1_rdata_o,
   output logic        m_en_o,
   output logic        m_we_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_wdata_o,
   output logic [3:0]  m_be_o,
   output logic        m_signed_o,
   input  logic [31:0] m_rdata_i
);

   arb_state_e            state_q, state_d;
   logic                  rr_last_q, rr_last_d;
   logic [1:0]            lock_owner_q, lock_owner_d;
   logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic                  rd_owner_q, rd_owner_d;
   logic [3:0]            held_be_q, held_be_d;
   logic                  held_signed_q, held_signed_d;
   logic [31:0]           held_addr_q, held_addr_d;
   logic [31:0]           held_wdata_q, held_wdata_d;

   logic [1:0]  w_req;
   logic        w_win;
   logic        w_pick_valid;
   logic        w_grant;
   logic [1:0]  w_gnt;
   logic        w_rvalid;
   logic        w_we;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [3:0]  w_be;
   logic        w_signed;
   logic        w_lock;
   logic        w_other_req;

   assign w_req = {r1_req_i, r0_req_i};

   rr_pick2 #(
      .LOCK_MAX   (LOCK_MAX),
      .LOCK_CNT_W (LOCK_CNT_W)
   ) u_pick (
      .req_i        (w_req),
      .rr_last_i    (rr_last_q),
      .lock_owner_i (lock_owner_q),
      .lock_cnt_i   (lock_cnt_q),
      .winner_o     (w_win),
      .valid_o      (w_pick_valid)
   );

   // Winner field mux
   assign w_we        = w_win ? r1_we_i     : r0_we_i;
   assign w_addr      = w_win ? r1_addr_i   : r0_addr_i;
   assign w_wdata     = w_win ? r1_wdata_i  : r0_wdata_i;
   assign w_be        = w_win ? r1_be_i     : r0_be_i;
   assign w_signed    = w_win ? r1_signed_i : r0_signed_i;
   assign w_lock      = w_win ? r1_lock_i   : r0_lock_i;
   assign w_other_req = w_req[~w_win];

   // resetb gates the grant so no access is accepted while reset is held.
   assign w_grant = (state_q == ST_IDLE) && w_pick_valid && resetb;

   always_comb begin
      state_d       = state_q;
      rr_last_d     = rr_last_q;
      lock_owner_d  = lock_owner_q;
      lock_cnt_d    = lock_cnt_q;
      rd_owner_d    = rd_owner_q;
      held_be_d     = held_be_q;
      held_signed_d = held_signed_q;
      held_addr_d   = held_addr_q;
      held_wdata_d  = held_wdata_q;
      w_gnt         = 2'b00;
      w_rvalid      = 1'b0;
      m_en_o        = 1'b0;
      m_we_o        = 1'b0;
      m_addr_o      = held_addr_q;
      m_wdata_o     = held_wdata_q;
      m_be_o        = BE_NONE;
      m_signed_o    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_grant) begin
               w_gnt[w_win] = 1'b1;
               m_en_o       = 1'b1;
               m_we_o       = w_we;
               m_addr_o     = w_addr;
               m_wdata_o    = w_wdata;
               m_be_o       = w_be;
               m_signed_o   = w_signed;
               rr_last_d    = w_win;
               held_addr_d  = w_addr;
               held_wdata_d = w_wdata;

               // Granting the non-owner always breaks an existing lock.
               if ((lock_owner_q != REQ_NONE) && (w_win != lock_owner_q[0])) begin
                  lock_owner_d = REQ_NONE;
                  lock_cnt_d   = '0;
               end else if (w_lock) begin
                  lock_owner_d = {1'b0, w_win};
                  if ((lock_owner_q != REQ_NONE) && w_other_req) begin
                     lock_cnt_d = (lock_cnt_q >= LOCK_CNT_W'(LOCK_MAX)) ?
                                  LOCK_CNT_W'(LOCK_MAX) : lock_cnt_q + 1'b1;
                  end else begin
                     lock_cnt_d = '0;
                  end
               end else begin
                  lock_owner_d = REQ_NONE;
                  lock_cnt_d   = '0;
               end

               if (!w_we) begin
                  state_d       = ST_RET;
                  rd_owner_d    = w_win;
                  held_be_d     = w_be;
                  held_signed_d = w_signed;
               end
            end
         end
         ST_RET: begin
            // MMU formats the load from live be/sign, so replay them here.
            m_be_o     = held_be_q;
            m_signed_o = held_signed_q;
            w_rvalid   = 1'b1;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q       <= ST_IDLE;
         rr_last_q     <= 1'b1;
         lock_owner_q  <= REQ_NONE;
         lock_cnt_q    <= '0;
         rd_owner_q    <= 1'b0;
         held_be_q     <= BE_NONE;
         held_signed_q <= 1'b0;
         held_addr_q   <= '0;
         held_wdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         rr_last_q     <= rr_last_d;
         lock_owner_q  <= lock_owner_d;
         lock_cnt_q    <= lock_cnt_d;
         rd_owner_q    <= rd_owner_d;
         held_be_q     <= held_be_d;
         held_signed_q <= held_signed_d;
         held_addr_q   <= held_addr_d;
         held_wdata_q  <= held_wdata_d;
      end
   end

   assign r0_gnt_o    = w_gnt[0];
   assign r1_gnt_o    = w_gnt[1];
   assign r0_rvalid_o = w_rvalid && !rd_owner_q;
   assign r1_rvalid_o = w_rvalid &&  rd_owner_q;
   assign r0_rdata_o  = r0_rvalid_o ? m_rdata_i : 32'd0;
   assign r1_rdata_o  = r1_rvalid_o ? m_rdata_i : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_port_arbiter
//  Description : Directed self-checking bench for dm_port_arbiter
//                (LOCK_MAX overridden to 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

   logic        clk = 1'b0;
   logic        resetb = 1'b0;
   logic        r0_req = 0, r0_we = 0, r0_signed = 0, r0_lock = 0;
   logic [31:0] r0_addr = 0, r0_wdata = 0;
   logic [3:0]  r0_be = 0;
   logic        r1_req = 0, r1_we = 0, r1_signed = 0, r1_lock = 0;
   logic [31:0] r1_addr = 0, r1_wdata = 0;
   logic [3:0]  r1_be = 0;
   logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [31:0] r0_rdata, r1_rdata;
   logic        m_en, m_we, m_signed;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   logic [31:0] m_rdata = 0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dm_port_arbiter #(.LOCK_MAX(4), .LOCK_CNT_W(5)) dut (
      .clk         (clk),
      .resetb      (resetb),
      .r0_req_i    (r0_req),
      .r0_we_i     (r0_we),
      .r0_addr_i   (r0_addr),
      .r0_wdata_i  (r0_wdata),
      .r0_be_i     (r0_be),
      .r0_signed_i (r0_signed),
      .r0_lock_i   (r0_lock),
      .r0_gnt_o    (r0_gnt),
      .r0_rvalid_o (r0_rvalid),
      .r0_rdata_o  (r0_rdata),
      .r1_req_i    (r1_req),
      .r1_we_i     (r1_we),
      .r1_addr_i   (r1_addr),
      .r1_wdata_i  (r1_wdata),
      .r1_be_i     (r1_be),
      .r1_signed_i (r1_signed),
      .r1_lock_i   (r1_lock),
      .r1_gnt_o    (r1_gnt),
      .r1_rvalid_o (r1_rvalid),
      .r1_rdata_o  (r1_rdata),
      .m_en_o      (m_en),
      .m_we_o      (m_we),
      .m_addr_o    (m_addr),
      .m_wdata_o   (m_wdata),
      .m_be_o      (m_be),
      .m_signed_o  (m_signed),
      .m_rdata_i   (m_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the active edge; outputs sampled at negedge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_r0(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic sgn, input logic lock);
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
      r0_be = be; r0_signed = sgn; r0_lock = lock;
   endtask

   task automatic set_r1(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic sgn, input logic lock);
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
      r1_be = be; r1_signed = sgn; r1_lock = lock;
   endtask

   task automatic do_reset();
      tick();
      resetb = 1'b0;
      tick();
      resetb = 1'b1;
   endtask

   logic exp_r1_lock [7] = '{1, 1, 1, 1, 1, 0, 1};

   initial begin
      // Reset state
      smp();
      chk("rst_r0_gnt", {31'd0, r0_gnt}, 32'd0);
      chk("rst_m_en", {31'd0, m_en}, 32'd0);
      chk("rst_m_be", {28'd0, m_be}, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
      tick();
      resetb = 1'b1;

      // 1. Single read by r0
      tick();
      set_r0(1, 0, 32'h1000_0004, 32'd0, 4'b1111, 0, 0);
      smp();
      chk("t1_r0_gnt", {31'd0, r0_gnt}, 32'd1);
      chk("t1_m_en", {31'd0, m_en}, 32'd1);
      chk("t1_m_addr", m_addr, 32'h1000_0004);
      chk("t1_m_we", {31'd0, m_we}, 32'd0);
      tick();
      set_r0(0, 0, 32'd0, 32'd0, 4'd0, 0, 0);
      m_rdata = 32'hDEAD_BEEF;
      smp();
      chk("t1_rvalid", {31'd0, r0_rvalid}, 32'd1);
      chk("t1_rdata", r0_rdata, 32'hDEAD_BEEF);
      chk("t1_ret_m_en", {31'd0, m_en}, 32'd0);
      chk("t1_ret_m_be", {28'd0, m_be}, 32'hF);
      chk("t1_ret_m_addr", m_addr, 32'h1000_0004);
      chk("t1_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
      chk("t1_r1_rdata", r1_rdata, 32'd0);
      tick();
      m_rdata = 32'h0;
      smp();
      chk("t1_idle_rvalid", {31'd0, r0_rvalid}, 32'd0);
      chk("t1_idle_m_be", {28'd0, m_be}, 32'd0);

      // 2. Signed byte load by r1; r0 waits through the return cycle
      tick();
      set_r1(1, 0, 32'h0000_0020, 32'd0, 4'b0001, 1, 0);
      smp();
      chk("t2_r1_gnt", {31'd0, r1_gnt}, 32'd1);
      chk("t2_m_signed", {31'd0, m_signed}, 32'd1);
      tick();
      set_r1(0, 0, 32'd0, 32'd0, 4'd0, 0, 0);
      set_r0(1, 1, 32'h0000_0030, 32'h55, 4'b1111, 0, 0);
      m_rdata = 32'h0000_0080;
      smp();
      chk("t2_ret_m_be", {28'd0, m_be}, 32'h1);
      chk("t2_ret_m_signed", {31'd0, m_signed}, 32'd1);
      chk("t2_ret_r0_gnt", {31'd0, r0_gnt}, 32'd0);
      chk("t2_r1_rvalid", {31'd0, r1_rvalid}, 32'd1);
      chk("t2_r1_rdata", r1_rdata, 32'h80);
      chk("t2_r0_rdata", r0_rdata, 32'd0);
      tick();
      m_rdata = 32'h0;
      smp();
      chk("t2_r0_gnt", {31'd0, r0_gnt}, 32'd1);
      chk("t2_m_we", {31'd0, m_we}, 32'd1);
      chk("t2_m_wdata", m_wdata, 32'h55);
      tick();
      set_r0(0, 0, 32'd0, 32'd0, 4'd0, 0, 0);

      // 3. Contention from reset: alternate r0, r1
      do_reset();
      set_r0(1, 1, 32'h100, 32'h1, 4'b1111, 0, 0);
      set_r1(1, 1, 32'h200, 32'h2, 4'b1111, 0, 0);
      for (int i = 0; i < 4; i++) begin
         smp();
         chk($sformatf("t3_r0_gnt_%0d", i), {31'd0, r0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("t3_r1_gnt_%0d", i), {31'd0, r1_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
         chk($sformatf("t3_m_addr_%0d", i), m_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
         tick();
      end
      set_r0(0, 0, 32'd0, 32'd0, 4'd0, 0, 0);
      set_r1(0, 0, 32'd0, 32'd0, 4'd0, 0, 0);

      // 4. Lock cap: r1 locks, r0 waits; five r1 grants, then r0, then rotation
      do_reset();
      set_r1(1, 1, 32'h300, 32'h3, 4'b1111, 0, 1);
      for (int i = 0; i < 7; i++) begin
         smp();
         chk($sformatf("t4_r1_gnt_%0d", i), {31'd0, r1_gnt}, {31'd0, exp_r1_lock[i]});
         chk($sformatf("t4_r0_gnt_%0d", i), {31'd0, r0_gnt}, {31'd0, ~exp_r1_lock[i]});
         tick();
         if (i == 0) set_r0(1, 1, 32'h400, 32'h4, 4'b1111, 0, 0);
      end
      set_r0(0, 0, 32'd0, 32'd0, 4'd0, 0, 0);
      set_r1(0, 0, 32'd0, 32'd0, 4'd0, 0, 0);

      // 5. Reset during the read return cycle
      tick();
      set_r0(1, 0, 32'h500, 32'd0, 4'b1111, 0, 0);
      smp();
      chk("t5_r0_gnt", {31'd0, r0_gnt}, 32'd1);
      tick();
      set_r0(1, 1, 32'h510, 32'h5, 4'b1111, 0, 0);
      set_r1(1, 1, 32'h520, 32'h6, 4'b1111, 0, 0);
      m_rdata = 32'hAAAA_5555;
      resetb = 1'b0;
      smp();
      chk("t5_rvalid", {31'd0, r0_rvalid}, 32'd0);
      chk("t5_rdata", r0_rdata, 32'd0);
      chk("t5_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd0);
      chk("t5_m_en", {31'd0, m_en}, 32'd0);
      chk("t5_m_addr", m_addr, 32'd0);
      chk("t5_m_be", {28'd0, m_be}, 32'd0);
      tick();
      m_rdata = 32'h0;
      resetb = 1'b1;
      smp();
      chk("t5_post_r0_gnt", {31'd0, r0_gnt}, 32'd1);
      chk("t5_post_r1_gnt", {31'd0, r1_gnt}, 32'd0);
      chk("t5_post_m_addr", m_addr, 32'h510);
      tick();
      set_r0(0, 0, 32'd0, 32'd0, 4'd0, 0, 0);
      set_r1(0, 0, 32'd0, 32'd0, 4'd0, 0, 0);

      // 6. r0 write then read back-to-back, next grant no earlier than T+3
      tick();
      set_r0(1, 1, 32'h600, 32'h66, 4'b1111, 0, 0);
      smp();
      chk("t6_w_gnt", {31'd0, r0_gnt}, 32'd1);
      chk("t6_w_m_we", {31'd0, m_we}, 32'd1);
      tick();
      set_r0(1, 0, 32'h604, 32'd0, 4'b0011, 0, 0);
      smp();
      chk("t6_r_gnt", {31'd0, r0_gnt}, 32'd1);
      chk("t6_r_m_we", {31'd0, m_we}, 32'd0);
      chk("t6_r_m_addr", m_addr, 32'h604);
      tick();
      set_r0(1, 0, 32'h608, 32'd0, 4'b1111, 0, 0);
      m_rdata = 32'h0000_1234;
      smp();
      chk("t6_rvalid", {31'd0, r0_rvalid}, 32'd1);
      chk("t6_rdata", r0_rdata, 32'h1234);
      chk("t6_ret_gnt", {31'd0, r0_gnt}, 32'd0);
      chk("t6_ret_m_be", {28'd0, m_be}, 32'h3);
      tick();
      m_rdata = 32'h0;
      smp();
      chk("t6_next_gnt", {31'd0, r0_gnt}, 32'd1);
      chk("t6_next_m_addr", m_addr, 32'h608);
      tick();
      set_r0(0, 0, 32'd0, 32'd0, 4'd0, 0, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
